// File: rtl/filtragem_pkg.sv
// Shared constants and types for the 3x3 median filter.
// TROCA_A/TROCA_B list the 19 compare-exchange pairs; after the last one, lane 4 holds the median.
package filtragem_pkg;

  localparam int N_AMOSTRAS  = 9;
  localparam int IDX_MEDIANA = 4;
  localparam int N_TROCAS    = 19;

  localparam int unsigned DATA_W = 8;
  typedef logic [DATA_W-1:0] amostra_t;

  // Each pair leaves the smaller value in lane TROCA_A and the larger in lane TROCA_B.
  localparam int TROCA_A [N_TROCAS] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
  localparam int TROCA_B [N_TROCAS] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

endpackage

// File: rtl/compara_troca.sv
// Unsigned compare-exchange cell: orders a and b into (menor, maior).
module compara_troca #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] menor,
  output logic [DATA_W-1:0] maior
);

  logic troca;

  assign troca = (a > b);
  assign menor = troca ? b : a;
  assign maior = troca ? a : b;

endmodule

// File: rtl/filtragem_mediana.sv
// 3x3 median filter: 19-exchange network feeding a registered result with a one-cycle valid flag.
module filtragem_mediana #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] n1_n,
  input  logic [DATA_W-1:0] n2_n,
  input  logic [DATA_W-1:0] n3_n,
  input  logic [DATA_W-1:0] n4_n,
  input  logic [DATA_W-1:0] n5_n,
  input  logic [DATA_W-1:0] n6_n,
  input  logic [DATA_W-1:0] n7_n,
  input  logic [DATA_W-1:0] n8_n,
  input  logic [DATA_W-1:0] n9_n,
  output logic [DATA_W-1:0] mediana,
  output logic              mediana_valid
);

  import filtragem_pkg::*;

  // rede[s] is the lane state before exchange s; rede[N_TROCAS] is the final state.
  logic [DATA_W-1:0] rede [N_TROCAS+1][N_AMOSTRAS];

  assign rede[0][0] = n1_n;
  assign rede[0][1] = n2_n;
  assign rede[0][2] = n3_n;
  assign rede[0][3] = n4_n;
  assign rede[0][4] = n5_n;
  assign rede[0][5] = n6_n;
  assign rede[0][6] = n7_n;
  assign rede[0][7] = n8_n;
  assign rede[0][8] = n9_n;

  for (genvar s = 0; s < N_TROCAS; s++) begin : g_troca
    // Lanes not touched by this exchange are wired straight through.
    for (genvar k = 0; k < N_AMOSTRAS; k++) begin : g_passa
      if (k != TROCA_A[s] && k != TROCA_B[s]) begin : g_fio
        assign rede[s+1][k] = rede[s][k];
      end
    end

    compara_troca #(
      .DATA_W (DATA_W)
    ) u_compara_troca (
      .a     (rede[s][TROCA_A[s]]),
      .b     (rede[s][TROCA_B[s]]),
      .menor (rede[s+1][TROCA_A[s]]),
      .maior (rede[s+1][TROCA_B[s]])
    );
  end

  // Output register; a window sampled together with rst is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mediana       <= '0;
      mediana_valid <= 1'b0;
    end else begin
      mediana_valid <= ena;
      if (ena) begin
        mediana <= rede[N_TROCAS][IDX_MEDIANA];
      end
    end
  end

endmodule

// File: tb/tb_filtragem_mediana.sv
// Self-checking bench for filtragem_mediana: directed vector table plus random windows vs. a sort model.
module tb_filtragem_mediana;

  typedef logic [8:0][7:0] janela_t;

  typedef struct {
    logic     rst;
    logic     ena;
    janela_t  win;
    logic [7:0] exp_m;
    logic     exp_v;
  } vetor_t;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] n [9];
  logic [7:0] mediana;
  logic       mediana_valid;

  int checks;
  int errors;

  vetor_t tabela [$];

  filtragem_mediana #(.DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .n1_n          (n[0]),
    .n2_n          (n[1]),
    .n3_n          (n[2]),
    .n4_n          (n[3]),
    .n5_n          (n[4]),
    .n6_n          (n[5]),
    .n7_n          (n[6]),
    .n8_n          (n[7]),
    .n9_n          (n[8]),
    .mediana       (mediana),
    .mediana_valid (mediana_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic janela_t mk(input int a0, input int a1, input int a2, input int a3,
                                 input int a4, input int a5, input int a6, input int a7,
                                 input int a8);
    janela_t w;
    w[0] = 8'(a0); w[1] = 8'(a1); w[2] = 8'(a2);
    w[3] = 8'(a3); w[4] = 8'(a4); w[5] = 8'(a5);
    w[6] = 8'(a6); w[7] = 8'(a7); w[8] = 8'(a8);
    return w;
  endfunction

  // Reference: sort all nine (duplicates kept), take the 5th smallest.
  function automatic logic [7:0] ref_mediana(input janela_t w);
    int v [9];
    for (int i = 0; i < 9; i++) v[i] = int'(w[i]);
    v.sort();
    return 8'(v[4]);
  endfunction

  task automatic add(input logic r, input logic e, input janela_t w,
                     input int em, input logic ev);
    vetor_t t;
    t.rst = r; t.ena = e; t.win = w; t.exp_m = 8'(em); t.exp_v = ev;
    tabela.push_back(t);
  endtask

  task automatic drive(input logic r, input logic e, input janela_t w);
    @(negedge clk);
    rst = r;
    ena = e;
    for (int i = 0; i < 9; i++) n[i] = w[i];
  endtask

  task automatic check(input string nome, input logic [7:0] em, input logic ev);
    checks++;
    if (mediana !== em) begin
      errors++;
      $display("FAIL %s: mediana=%0d expected %0d", nome, mediana, em);
    end
    checks++;
    if (mediana_valid !== ev) begin
      errors++;
      $display("FAIL %s: mediana_valid=%0b expected %0b", nome, mediana_valid, ev);
    end
  endtask

  task automatic step(input string nome, input logic r, input logic e, input janela_t w,
                      input logic [7:0] em, input logic ev);
    drive(r, e, w);
    @(posedge clk);
    #1;
    check(nome, em, ev);
  endtask

  initial begin
    janela_t asc, desc, sete, dup9, dup255, misto, w;
    logic [7:0] exp_m;
    logic       exp_v;
    int         habilitadas;
    int         ciclos;
    int         modo;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    ena = 1'b0;
    for (int i = 0; i < 9; i++) n[i] = '0;

    asc    = mk(0, 1, 2, 3, 4, 5, 6, 7, 8);
    desc   = mk(8, 7, 6, 5, 4, 3, 2, 1, 0);
    sete   = mk(7, 7, 7, 7, 7, 7, 7, 7, 7);
    dup9   = mk(0, 0, 0, 0, 9, 9, 9, 9, 9);
    dup255 = mk(255, 255, 255, 255, 255, 0, 0, 0, 0);
    misto  = mk(5, 200, 17, 99, 3, 42, 128, 64, 8);

    // Reset with ena high, then single windows, hold, back-to-back, reset mid-stream.
    add(1, 1, asc,    0,   0);
    add(1, 0, desc,   0,   0);
    add(0, 1, asc,    4,   1);
    add(0, 1, desc,   4,   1);
    add(0, 1, sete,   7,   1);
    add(0, 1, dup9,   9,   1);
    add(0, 1, dup255, 255, 1);
    add(0, 1, misto,  42,  1);
    add(0, 1, asc,    4,   1);
    add(0, 0, desc,   4,   0);
    add(0, 0, dup255, 4,   0);
    add(0, 0, sete,   4,   0);
    add(0, 1, asc,    4,   1);
    add(0, 1, sete,   7,   1);
    add(0, 1, desc,   4,   1);
    add(1, 1, sete,   0,   0);
    add(0, 0, dup255, 0,   0);
    add(0, 1, dup9,   9,   1);

    foreach (tabela[i]) begin
      step($sformatf("vec%0d", i), tabela[i].rst, tabela[i].ena, tabela[i].win,
           tabela[i].exp_m, tabela[i].exp_v);
    end

    // Random windows; narrow-range lanes force duplicates, idle cycles check hold.
    exp_m = 8'd9;
    habilitadas = 0;
    ciclos = 0;
    while (habilitadas < 1000 && ciclos < 5000) begin
      ciclos++;
      modo = int'($urandom_range(0, 2));
      for (int i = 0; i < 9; i++) begin
        case (modo)
          0:       w[i] = 8'($urandom_range(0, 255));
          1:       w[i] = 8'($urandom_range(0, 3));
          default: w[i] = 8'($urandom_range(0, 7));
        endcase
      end
      exp_v = ($urandom_range(0, 7) != 0);
      if (exp_v) begin
        exp_m = ref_mediana(w);
        habilitadas++;
      end
      step($sformatf("rand%0d", ciclos), 1'b0, exp_v, w, exp_m, exp_v);
    end
    checks++;
    if (habilitadas != 1000) begin
      errors++;
      $display("FAIL rand_count: enabled=%0d expected 1000", habilitadas);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
